// File: rtl/sd_rx.sv
// sd_rx: serial frame receiver with a small output FIFO.
//
// The trigger/storage controller sends frames on a single line, one bit
// per clk. The line idles low; a 0->1 transition opens a frame. Each byte
// is one low start bit followed by 8 data bits, MSB first. The line is
// high for at least one cycle between bytes. Received bytes are queued
// together with their 0-based position in the frame.
//
// Parameters
//   FRAME_BYTES : bytes per frame (1..255)
//   FIFO_DEPTH  : output FIFO entries (power of 2, >= 2)
//
// Ports
//   clk        : sole clock, rising edge
//   reset      : synchronous, active-high
//   sd         : serial data line
//   byte_dat   : FIFO head byte (0 while empty)
//   byte_vld   : FIFO non-empty
//   byte_rdy   : consumer pops the head when byte_vld && byte_rdy
//   byte_idx   : frame index of the head byte (0 while empty)
//   frame_done : one-cycle pulse when the last frame byte is received
//   ovf        : sticky, set when a received byte was dropped (FIFO full)
module sd_rx #(
  parameter int FRAME_BYTES = 32,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sd,
  output logic [7:0] byte_dat,
  output logic       byte_vld,
  input  logic       byte_rdy,
  output logic [7:0] byte_idx,
  output logic       frame_done,
  output logic       ovf
);

  localparam int BC_W  = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  logic             sd_q;
  logic             sd_prev;
  // sq_ok/prev_ok mark that sd_q/sd_prev hold real line samples taken
  // after reset; a line already high at reset release is not a 0->1 edge.
  logic             sq_ok;
  logic             prev_ok;

  logic [1:0]       state;
  logic [2:0]       bit_cnt;
  logic [BC_W-1:0]  byte_cnt;
  logic [6:0]       sr;

  logic [7:0]       dat_mem [FIFO_DEPTH];
  logic [7:0]       idx_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic             push_req;
  logic             last_byte;
  logic             pop;
  logic             fifo_full;
  logic             accept;
  logic [7:0]       push_byte;

  assign push_req  = (state == S_DATA) && (bit_cnt == 3'd7);
  assign last_byte = (byte_cnt == BC_W'(FRAME_BYTES - 1));
  assign push_byte = {sr, sd_q};

  assign byte_vld  = (count != '0);
  assign pop       = byte_vld && byte_rdy;
  assign fifo_full = (count == CNT_W'(FIFO_DEPTH));
  // A full FIFO still takes the byte when the head leaves in the same cycle.
  assign accept    = push_req && (!fifo_full || pop);

  // Output gating keeps stale storage invisible while the FIFO is empty.
  assign byte_dat  = byte_vld ? dat_mem[rd_ptr] : 8'h00;
  assign byte_idx  = byte_vld ? idx_mem[rd_ptr] : 8'h00;

  // Stage 0: line sampling and edge history
  always_ff @(posedge clk) begin
    if (reset) begin
      sd_q    <= 1'b0;
      sd_prev <= 1'b0;
      sq_ok   <= 1'b0;
      prev_ok <= 1'b0;
    end else begin
      sd_q    <= sd;
      sd_prev <= sd_q;
      sq_ok   <= 1'b1;
      prev_ok <= sq_ok;
    end
  end

  // Stage 1: frame/byte state machine on sd_q
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (sd_q && !sd_prev && prev_ok) begin
            byte_cnt <= '0;
            state    <= S_ARM;
          end
        end
        S_ARM: begin
          if (!sd_q) begin
            bit_cnt <= '0;
            state   <= S_DATA;
          end
        end
        S_DATA: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            byte_cnt <= byte_cnt + BC_W'(1);
            if (last_byte) begin
              frame_done <= 1'b1;
              state      <= S_IDLE;
            end else begin
              state      <= S_ARM;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_DATA) begin
      sr <= {sr[5:0], sd_q};
    end
  end

  // Stage 2: output FIFO
  always_ff @(posedge clk) begin
    if (accept) begin
      dat_mem[wr_ptr] <= push_byte;
      idx_mem[wr_ptr] <= 8'(byte_cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({accept, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (push_req && !accept) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sd_rx.sv
// Bench for sd_rx: two instances (FRAME_BYTES=32 on line A, FRAME_BYTES=2
// on line B). Stimulus pushes the expected {idx, byte} into a per-instance
// queue; a negedge monitor pops and compares whenever a byte is consumed.
module tb_sd_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic       sd_a, sd_b;
  logic       rdy_a, rdy_b;
  logic [7:0] dat_a, dat_b, idx_a, idx_b;
  logic       vld_a, vld_b, fd_a, fd_b, ovf_a, ovf_b;

  always #5 clk = ~clk;

  sd_rx #(.FRAME_BYTES(32), .FIFO_DEPTH(4)) u_dut_a (
    .clk(clk), .reset(reset), .sd(sd_a),
    .byte_dat(dat_a), .byte_vld(vld_a), .byte_rdy(rdy_a),
    .byte_idx(idx_a), .frame_done(fd_a), .ovf(ovf_a)
  );

  sd_rx #(.FRAME_BYTES(2), .FIFO_DEPTH(4)) u_dut_b (
    .clk(clk), .reset(reset), .sd(sd_b),
    .byte_dat(dat_b), .byte_vld(vld_b), .byte_rdy(rdy_b),
    .byte_idx(idx_b), .frame_done(fd_b), .ovf(ovf_b)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          fd_cnt_a = 0;
  int          fd_cnt_b = 0;
  logic [15:0] q_a[$];
  logic [15:0] q_b[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Monitors: compare each consumed byte against the scoreboard head.
  always @(negedge clk) begin
    if (!reset) begin
      if (fd_a) fd_cnt_a++;
      if (vld_a && rdy_a) begin
        if (q_a.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL a_unexpected_pop: got idx %0d dat %0h required no byte", idx_a, dat_a);
        end else begin
          logic [15:0] e;
          e = q_a.pop_front();
          check("a_dat", {24'h0, dat_a}, {24'h0, e[7:0]});
          check("a_idx", {24'h0, idx_a}, {24'h0, e[15:8]});
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (fd_b) fd_cnt_b++;
      if (vld_b && rdy_b) begin
        if (q_b.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL b_unexpected_pop: got idx %0d dat %0h required no byte", idx_b, dat_b);
        end else begin
          logic [15:0] e;
          e = q_b.pop_front();
          check("b_dat", {24'h0, dat_b}, {24'h0, e[7:0]});
          check("b_idx", {24'h0, idx_b}, {24'h0, e[15:8]});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit sel_b, input logic v);
    if (sel_b) sd_b = v;
    else       sd_a = v;
  endtask

  // Low for two cycles, then the 0->1 edge that opens a frame.
  task automatic frame_start(input bit sel_b);
    drive(sel_b, 1'b0);
    tick();
    tick();
    drive(sel_b, 1'b1);
    tick();
  endtask

  // Start bit, 8 data bits MSB first, then `gap` high cycles. With
  // pulse_rdy, rdy_a is high exactly in the cycle whose closing edge
  // pushes this byte.
  task automatic send_byte(input bit sel_b, input logic [7:0] v, input int gap, input bit pulse_rdy);
    drive(sel_b, 1'b0);
    tick();
    for (int i = 7; i >= 0; i--) begin
      drive(sel_b, v[i]);
      tick();
    end
    drive(sel_b, 1'b1);
    if (pulse_rdy) rdy_a = 1'b1;
    tick();
    if (pulse_rdy) rdy_a = 1'b0;
    for (int g = 1; g < gap; g++) tick();
  endtask

  task automatic wait_drain_a();
    int t;
    t = 0;
    while ((q_a.size() != 0 || vld_a) && t < 500) begin
      tick();
      t++;
    end
    tick();
    check("a_queue_left", q_a.size(), 0);
    check("a_vld_after_drain", {31'h0, vld_a}, 0);
  endtask

  task automatic wait_drain_b();
    int t;
    t = 0;
    while ((q_b.size() != 0 || vld_b) && t < 500) begin
      tick();
      t++;
    end
    tick();
    check("b_queue_left", q_b.size(), 0);
    check("b_vld_after_drain", {31'h0, vld_b}, 0);
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Line A high from time zero: no low has been seen, so no frame start.
    reset = 1'b1;
    sd_a  = 1'b1;
    sd_b  = 1'b0;
    rdy_a = 1'b0;
    rdy_b = 1'b0;
    repeat (3) tick();
    check("rst_a_vld", {31'h0, vld_a}, 0);
    check("rst_a_dat", {24'h0, dat_a}, 0);
    check("rst_a_idx", {24'h0, idx_a}, 0);
    check("rst_a_fd",  {31'h0, fd_a}, 0);
    check("rst_a_ovf", {31'h0, ovf_a}, 0);
    check("rst_b_vld", {31'h0, vld_b}, 0);
    reset = 1'b0;
    repeat (20) tick();
    check("a_no_spurious_vld", {31'h0, vld_a}, 0);

    // Two-byte frame on B.
    rdy_b = 1'b1;
    frame_start(1'b1);
    q_b.push_back({8'd0, 8'hA5});
    send_byte(1'b1, 8'hA5, 1, 1'b0);
    q_b.push_back({8'd1, 8'h3C});
    send_byte(1'b1, 8'h3C, 2, 1'b0);
    wait_drain_b();
    check("b_frame_done_cnt", fd_cnt_b, 1);
    check("b_ovf", {31'h0, ovf_b}, 0);

    // Full 32-byte frame on A, one long high gap mid-frame.
    rdy_a = 1'b1;
    frame_start(1'b0);
    for (int i = 0; i < 32; i++) begin
      q_a.push_back({8'(i), 8'(i)});
      send_byte(1'b0, 8'(i), (i == 10) ? 10 : 1, 1'b0);
    end
    wait_drain_a();
    check("a_frame_done_cnt1", fd_cnt_a, 1);
    check("a_ovf_after_frame", {31'h0, ovf_a}, 0);

    // Consumer stalled: 6 bytes, only the first 4 fit.
    rdy_a = 1'b0;
    frame_start(1'b0);
    for (int i = 0; i < 6; i++) begin
      if (i < 4) q_a.push_back({8'(i), 8'(8'hA0 + i)});
      send_byte(1'b0, 8'(8'hA0 + i), 1, 1'b0);
      if (i == 3) check("ovf_after_4th", {31'h0, ovf_a}, 0);
      if (i == 4) check("ovf_after_5th", {31'h0, ovf_a}, 1);
    end
    check("stall_head_dat", {24'h0, dat_a}, 32'hA0);
    check("stall_head_idx", {24'h0, idx_a}, 0);
    repeat (3) tick();
    check("stall_hold_dat", {24'h0, dat_a}, 32'hA0);
    check("ovf_sticky", {31'h0, ovf_a}, 1);
    rdy_a = 1'b1;
    wait_drain_a();
    reset_pulse();
    tick();
    check("ovf_cleared_by_reset", {31'h0, ovf_a}, 0);

    // Full FIFO with a pop in the push cycle of byte 5: nothing dropped.
    rdy_a = 1'b0;
    frame_start(1'b0);
    for (int i = 0; i < 5; i++) begin
      q_a.push_back({8'(i), 8'(8'h50 + i)});
      send_byte(1'b0, 8'(8'h50 + i), 1, i == 4);
    end
    check("ovf_pop_push_same_cycle", {31'h0, ovf_a}, 0);
    rdy_a = 1'b1;
    wait_drain_a();
    check("ovf_after_drain", {31'h0, ovf_a}, 0);

    // Reset mid-byte with a byte waiting in the FIFO.
    reset_pulse();
    rdy_a = 1'b0;
    frame_start(1'b0);
    send_byte(1'b0, 8'h11, 1, 1'b0);
    drive(1'b0, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1);
      tick();
    end
    reset = 1'b1;
    tick();
    check("midrst_vld", {31'h0, vld_a}, 0);
    check("midrst_dat", {24'h0, dat_a}, 0);
    check("midrst_idx", {24'h0, idx_a}, 0);
    check("midrst_fd",  {31'h0, fd_a}, 0);
    check("midrst_ovf", {31'h0, ovf_a}, 0);
    reset = 1'b0;
    repeat (10) tick();
    check("midrst_no_restart", {31'h0, vld_a}, 0);
    rdy_a = 1'b1;
    frame_start(1'b0);
    for (int i = 0; i < 32; i++) begin
      q_a.push_back({8'(i), 8'(8'h40 + i)});
      send_byte(1'b0, 8'(8'h40 + i), 1, 1'b0);
    end
    wait_drain_a();
    check("a_frame_done_cnt2", fd_cnt_a, 2);
    check("b_frame_done_final", fd_cnt_b, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
